// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the UART transmitter.
// Combinational bundle, no storage.
// Producer drives valid/data; transmitter drives ready.
interface uart_tx_if;
   logic       i_tx_valid;
   logic [7:0] i_tx_data;
   logic       o_tx_ready;

   modport master (
      output i_tx_valid,
      output i_tx_data,
      input  o_tx_ready
   );

   modport slave (
      input  i_tx_valid,
      input  i_tx_data,
      output o_tx_ready
   );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter, 8 data bits, no parity, 1 or 2 stop bits, LSB first, fed by a small byte FIFO.
// Latency: start bit begins on the first baud tick at least one cycle after a byte is accepted.
// Backpressure: o_tx_ready drops when the FIFO holds FIFO_DEPTH bytes; producer holds valid/data.
module uart_tx #(
   parameter int FIFO_DEPTH = 4,
   parameter int STOP_BITS  = 1
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_signal,
   uart_tx_if.slave                      tx,
   output logic                          o_stx,
   output logic                          o_busy,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t        state;
   logic [7:0]    shift;
   logic [2:0]    bit_cnt;
   logic          stop_cnt;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   logic          push;
   logic          pop;
   logic          fifo_nempty;
   logic          last_stop;
   logic [7:0]    head;

   // Ready is a pure function of the stored count, so a full FIFO refuses a byte even in a pop cycle.
   assign tx.o_tx_ready = (o_fifo_count < CW'(FIFO_DEPTH));
   assign push          = tx.i_tx_valid & tx.o_tx_ready;
   assign fifo_nempty   = (o_fifo_count != '0);
   assign head          = mem[rd_ptr];

   // With a single stop bit every STOP tick is the last one; otherwise the second one is.
   assign last_stop = (STOP_BITS == 1) || stop_cnt;

   // A byte leaves the FIFO on the tick that starts its frame (from IDLE or straight after the last stop bit).
   // The count is registered, so a byte written this cycle cannot be popped until the next one.
   always_comb begin
      pop = 1'b0;
      if (i_signal && fifo_nempty) begin
         if (state == IDLE)
            pop = 1'b1;
         else if (state == STOP && last_stop)
            pop = 1'b1;
      end
   end

   // FIFO storage: written on accept, no reset needed since the count gates every read.
   always_ff @(posedge i_clk) begin
      if (push)
         mem[wr_ptr] <= tx.i_tx_data;
   end

   // FIFO pointers and occupancy; pointers wrap naturally because the depth is a power of two.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         o_fifo_count <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   o_fifo_count <= o_fifo_count + 1'b1;
            2'b01:   o_fifo_count <= o_fifo_count - 1'b1;
            default: o_fifo_count <= o_fifo_count;
         endcase
      end
   end

   // Frame sequencer: every line level is set on a baud tick and held until the next one.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state    <= IDLE;
         o_stx    <= 1'b1;
         o_busy   <= 1'b0;
         shift    <= '0;
         bit_cnt  <= '0;
         stop_cnt <= 1'b0;
      end else if (i_signal) begin
         case (state)
            IDLE: begin
               if (fifo_nempty) begin
                  state  <= START;
                  shift  <= head;
                  o_stx  <= 1'b0;
                  o_busy <= 1'b1;
               end else begin
                  o_stx  <= 1'b1;
               end
            end
            START: begin
               state   <= DATA;
               o_stx   <= shift[0];
               shift   <= {1'b0, shift[7:1]};
               bit_cnt <= '0;
            end
            DATA: begin
               if (bit_cnt == 3'd7) begin
                  state    <= STOP;
                  o_stx    <= 1'b1;
                  stop_cnt <= 1'b0;
               end else begin
                  o_stx   <= shift[0];
                  shift   <= {1'b0, shift[7:1]};
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            STOP: begin
               if (!last_stop) begin
                  stop_cnt <= 1'b1;
               end else if (fifo_nempty) begin
                  // Next frame starts immediately: no idle bit between frames.
                  state <= START;
                  shift <= head;
                  o_stx <= 1'b0;
               end else begin
                  state  <= IDLE;
                  o_busy <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               o_stx  <= 1'b1;
               o_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: per-cycle comparison against a queue-based line model,
// plus directed bit-pattern checks and a frame decoder on the sampled line.
// Two instances cover one and two stop bits; only the selected one is driven and checked.
module tb_uart_tx;
   localparam int DEPTH = 4;

   logic       i_clk = 1'b0;
   logic       i_rst_n;
   logic       sig0, sig1;
   logic       stx0, stx1, busy0, busy1;
   logic [2:0] cnt0, cnt1;

   uart_tx_if if0 ();
   uart_tx_if if1 ();

   uart_tx #(.FIFO_DEPTH(DEPTH), .STOP_BITS(1)) dut0 (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_signal(sig0), .tx(if0.slave),
      .o_stx(stx0), .o_busy(busy0), .o_fifo_count(cnt0));

   uart_tx #(.FIFO_DEPTH(DEPTH), .STOP_BITS(2)) dut1 (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_signal(sig1), .tx(if1.slave),
      .o_stx(stx1), .o_busy(busy1), .o_fifo_count(cnt1));

   always #5 i_clk = ~i_clk;

   int   checks = 0;
   int   errors = 0;
   bit   sel;
   int   nsb;
   int   per;
   bit   tick_en;
   int   phase;
   bit   v_in;
   logic [7:0] d_in;

   // Reference model: bytes waiting, line levels still to send for the current frame.
   logic [7:0] mq[$];
   bit         pend[$];
   bit         m_stx;
   bit         m_busy;
   bit         last_acc;

   bit         obs_q[$];
   bit         exp_q[$];
   logic [7:0] sent_q[$];
   logic [7:0] dec_q[$];

   logic       stx_m, busy_m, rdy_m;
   logic [2:0] cnt_m;
   assign stx_m  = sel ? stx1  : stx0;
   assign busy_m = sel ? busy1 : busy0;
   assign cnt_m  = sel ? cnt1  : cnt0;
   assign rdy_m  = sel ? if1.o_tx_ready : if0.o_tx_ready;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      mq.delete();
      pend.delete();
      m_stx  = 1'b1;
      m_busy = 1'b0;
   endtask

   // One clock: drive inputs, advance the model at the edge, compare 1 time unit later.
   task automatic cycle(input bit force_tick);
      bit         tk;
      bit         push_ok;
      logic [7:0] d;
      tk = force_tick || (tick_en && (phase % per == per - 1));
      phase++;
      sig0 = tk && !sel;
      sig1 = tk && sel;
      if0.i_tx_valid = v_in && !sel;
      if0.i_tx_data  = d_in;
      if1.i_tx_valid = v_in && sel;
      if1.i_tx_data  = d_in;
      @(posedge i_clk);
      last_acc = 1'b0;
      if (!i_rst_n) begin
         model_clear();
      end else begin
         push_ok = v_in && (mq.size() < DEPTH);
         if (tk) begin
            if (pend.size() == 0 && mq.size() != 0) begin
               d = mq.pop_front();
               pend.push_back(1'b0);
               for (int k = 0; k < 8; k++) pend.push_back(d[k]);
               for (int s = 0; s < nsb; s++) pend.push_back(1'b1);
               m_busy = 1'b1;
            end
            if (pend.size() != 0) begin
               m_stx = pend.pop_front();
            end else begin
               m_stx  = 1'b1;
               m_busy = 1'b0;
            end
         end
         if (push_ok) begin
            mq.push_back(d_in);
            sent_q.push_back(d_in);
         end
         last_acc = push_ok;
      end
      #1;
      check("stx",   32'(stx_m),  32'(m_stx));
      check("busy",  32'(busy_m), 32'(m_busy));
      check("count", 32'(cnt_m),  32'(mq.size()));
      check("ready", 32'(rdy_m),  32'(mq.size() < DEPTH));
      if (tk && i_rst_n) obs_q.push_back(stx_m);
   endtask

   task automatic run(input int n);
      repeat (n) cycle(1'b0);
   endtask

   task automatic send(input logic [7:0] d);
      int n;
      n    = 0;
      v_in = 1'b1;
      d_in = d;
      do begin
         cycle(1'b0);
         n++;
      end while (!last_acc && n < 3000);
      check("accept_timeout", 32'(last_acc), 32'd1);
      v_in = 1'b0;
   endtask

   // Asynchronous reset: outputs must settle before any clock edge.
   task automatic do_reset();
      i_rst_n = 1'b0;
      #1;
      check("rst_stx",   32'(stx_m),  32'd1);
      check("rst_count", 32'(cnt_m),  32'd0);
      check("rst_ready", 32'(rdy_m),  32'd1);
      check("rst_busy",  32'(busy_m), 32'd0);
      model_clear();
      nsb     = sel ? 2 : 1;
      tick_en = 1'b0;
      v_in    = 1'b0;
      run(2);
      i_rst_n = 1'b1;
      phase   = 0;
      obs_q.delete();
      sent_q.delete();
   endtask

   task automatic push_frame(input logic [7:0] d);
      exp_q.push_back(1'b0);
      for (int k = 0; k < 8; k++) exp_q.push_back(d[k]);
      for (int s = 0; s < nsb; s++) exp_q.push_back(1'b1);
   endtask

   // Compare sampled line levels, from the first start bit on, against exp_q.
   task automatic check_levels(input string tag);
      int idx;
      idx = -1;
      for (int i = 0; i < obs_q.size(); i++)
         if (idx < 0 && obs_q[i] == 1'b0) idx = i;
      check({tag, "_start_seen"}, 32'(idx >= 0), 32'd1);
      if (idx >= 0) begin
         check({tag, "_len"}, 32'(obs_q.size() - idx >= exp_q.size()), 32'd1);
         for (int k = 0; k < exp_q.size() && idx + k < obs_q.size(); k++)
            check($sformatf("%s_lvl%0d", tag, k), 32'(obs_q[idx + k]), 32'(exp_q[k]));
      end
      exp_q.delete();
   endtask

   // Decode frames from sampled levels and compare against every byte accepted.
   task automatic check_decode(input string tag);
      int         i;
      logic [7:0] d;
      i = 0;
      dec_q.delete();
      while (i + 8 + nsb < obs_q.size()) begin
         if (obs_q[i] == 1'b0) begin
            for (int k = 0; k < 8; k++) d[k] = obs_q[i + 1 + k];
            for (int s = 0; s < nsb; s++)
               check({tag, "_stopbit"}, 32'(obs_q[i + 9 + s]), 32'd1);
            dec_q.push_back(d);
            i += 9 + nsb;
         end else begin
            i++;
         end
      end
      check({tag, "_nframes"}, 32'(dec_q.size()), 32'(sent_q.size()));
      for (int j = 0; j < dec_q.size() && j < sent_q.size(); j++)
         check($sformatf("%s_byte%0d", tag, j), 32'(dec_q[j]), 32'(sent_q[j]));
   endtask

   initial begin
      int zeros;
      i_rst_n = 1'b1;
      sel = 1'b0; nsb = 1; per = 16; tick_en = 1'b0; phase = 0;
      v_in = 1'b0; d_in = 8'h00;
      sig0 = 1'b0; sig1 = 1'b0;
      model_clear();
      #2;

      // T1: single byte on an idle line
      sel = 1'b0; do_reset();
      per = 16; tick_en = 1'b1;
      send(8'hA5);
      run(13 * 16);
      exp_q = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
      check_levels("T1");
      check("T1_idle_busy", 32'(busy_m), 32'd0);
      check("T1_idle_stx",  32'(stx_m),  32'd1);

      // T2: back-to-back frames, no idle bit between them
      do_reset();
      per = 8; tick_en = 1'b1;
      send(8'h00);
      send(8'hFF);
      run(24 * 8);
      push_frame(8'h00);
      push_frame(8'hFF);
      check_levels("T2");
      check_decode("T2");

      // T3: fill the FIFO with no ticks; fifth byte waits for the first pop
      do_reset();
      for (int k = 0; k < 4; k++) send(8'h10 + 8'(k));
      check("T3_count4", 32'(cnt_m), 32'd4);
      check("T3_ready0", 32'(rdy_m), 32'd0);
      v_in = 1'b1; d_in = 8'h99;
      run(6);
      check("T3_held", 32'(last_acc), 32'd0);
      per = 6; phase = 0; tick_en = 1'b1;
      send(8'h99);
      run(6 * 11 * 6);
      check_decode("T3");

      // T4: write and pop in the same cycle at count 2
      do_reset();
      send(8'h3A);
      send(8'hC5);
      check("T4_count2_pre", 32'(cnt_m), 32'd2);
      v_in = 1'b1; d_in = 8'h7E;
      cycle(1'b1);
      v_in = 1'b0;
      check("T4_acc",    32'(last_acc), 32'd1);
      check("T4_count2", 32'(cnt_m),    32'd2);
      per = 6; phase = 0; tick_en = 1'b1;
      run(6 * 11 * 4);
      check_decode("T4");

      // T5: two stop bits, two queued bytes
      sel = 1'b1; do_reset();
      per = 8; tick_en = 1'b1;
      send(8'h5A);
      send(8'hC3);
      run(26 * 8);
      push_frame(8'h5A);
      push_frame(8'hC3);
      check_levels("T5");
      check_decode("T5");

      // Random traffic on both stop-bit settings
      for (int r = 0; r < 2; r++) begin
         sel = r[0]; do_reset();
         per = $urandom_range(4, 12); tick_en = 1'b1;
         for (int b = 0; b < 15; b++) begin
            run($urandom_range(0, 20));
            send(8'($urandom));
         end
         run(per * 11 * (DEPTH + 2));
         check_decode($sformatf("RND%0d", r));
      end

      // T6: reset in the middle of a data bit, then a quiet line
      sel = 1'b0; do_reset();
      per = 16; tick_en = 1'b1;
      send(8'h3C);
      run(5 * 16);
      check("T6_busy_pre", 32'(busy_m), 32'd1);
      do_reset();
      tick_en = 1'b1;
      run(200);
      zeros = 0;
      foreach (obs_q[i]) if (obs_q[i] == 1'b0) zeros++;
      check("T6_quiet", 32'(zeros), 32'd0);
      check("T6_busy",  32'(busy_m), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
